// File: rtl/nes_dma_pkg.sv
// Shared definitions for the NES sprite DMA block: state encoding,
// default register addresses and the nominal stall lengths.
package nes_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDRESS_DEFAULT = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDRESS_DEFAULT = 16'h2004;

    // RDY-low length of one transfer with the halt cycle on a put / get cycle
    localparam int STALL_EVEN = 513;
    localparam int STALL_ODD  = 514;

endpackage

// File: rtl/oam_dma_controller.sv
// OAM sprite DMA sequencer. A CPU write to DMA_REG_ADDRESS stalls the core
// through RDY, then copies 256 bytes from page $XX00 to OAMDATA, alternating
// read (get) and write (put) cycles aligned to a free-running parity flop.
// Optional build macro OAM_DMA_STALL_COUNT_EN adds o_stall_cycles, the number
// of RDY-low cycles of the current/last transfer.
module oam_dma_controller
    import nes_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDRESS = DMA_REG_ADDRESS_DEFAULT,
    parameter logic [15:0] OAMDATA_ADDRESS = OAMDATA_ADDRESS_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_cpu_address,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_cpu_data,
    input  logic [7:0]  i_bus_data,
    output logic        o_rdy,
    output logic        o_dma_active,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data
`ifdef OAM_DMA_STALL_COUNT_EN
    ,
    output logic [9:0]  o_stall_cycles
`endif
);

    dma_state_t state;
    logic       r_get;
    logic [7:0] page;
    logic [7:0] index;
    logic       trigger;

    assign trigger = (i_cpu_address == DMA_REG_ADDRESS) && !i_cpu_rw;

    // Get/put parity: high on cycles where a DMA read may be issued
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_get <= 1'b0;
        end else begin
            r_get <= ~r_get;
        end
    end

    // Transfer sequencer; o_data doubles as the byte buffer between READ and WRITE
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_IDLE;
            page         <= 8'h00;
            index        <= 8'h00;
            o_rdy        <= 1'b1;
            o_dma_active <= 1'b0;
            o_address    <= 16'h0000;
            o_rw         <= 1'b1;
            o_data       <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        page  <= i_cpu_data;
                        index <= 8'h00;
                        o_rdy <= 1'b0;
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // Core ignores RDY on writes, so wait for its first read cycle
                    if (i_cpu_rw) begin
                        if (!r_get) begin
                            state        <= ST_READ;
                            o_dma_active <= 1'b1;
                            o_address    <= {page, index};
                            o_rw         <= 1'b1;
                        end else begin
                            state <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    state        <= ST_READ;
                    o_dma_active <= 1'b1;
                    o_address    <= {page, index};
                    o_rw         <= 1'b1;
                end
                ST_READ: begin
                    state     <= ST_WRITE;
                    o_address <= OAMDATA_ADDRESS;
                    o_rw      <= 1'b0;
                    o_data    <= i_bus_data;
                end
                ST_WRITE: begin
                    if (index == 8'hFF) begin
                        state        <= ST_IDLE;
                        o_rdy        <= 1'b1;
                        o_dma_active <= 1'b0;
                        o_rw         <= 1'b1;
                    end else begin
                        index     <= index + 8'd1;
                        state     <= ST_READ;
                        o_address <= {page, index + 8'd1};
                        o_rw      <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    o_rdy        <= 1'b1;
                    o_dma_active <= 1'b0;
                    o_rw         <= 1'b1;
                end
            endcase
        end
    end

`ifdef OAM_DMA_STALL_COUNT_EN
    // RDY-low cycle counter, restarted by each accepted trigger
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stall_cycles <= 10'd0;
        end else if ((state == ST_IDLE) && trigger) begin
            o_stall_cycles <= 10'd0;
        end else if (!o_rdy) begin
            o_stall_cycles <= o_stall_cycles + 10'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: a table of transfer scenarios
// (page, data pattern, core write cycles, halt parity, expected stall)
// plus hand sequences for reset and mid-transfer reset.
module tb_oam_dma_controller;
    import nes_dma_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [15:0] i_cpu_address = 16'h0000;
    logic        i_cpu_rw = 1'b1;
    logic [7:0]  i_cpu_data = 8'h00;
    logic [7:0]  i_bus_data;
    logic        o_rdy;
    logic        o_dma_active;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
`ifdef OAM_DMA_STALL_COUNT_EN
    logic [9:0]  o_stall_cycles;
`endif

    int total = 0;
    int bad = 0;
    logic [7:0] bus_mask = 8'h00;
    logic tb_get;

    oam_dma_controller dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cpu_address (i_cpu_address),
        .i_cpu_rw      (i_cpu_rw),
        .i_cpu_data    (i_cpu_data),
        .i_bus_data    (i_bus_data),
        .o_rdy         (o_rdy),
        .o_dma_active  (o_dma_active),
        .o_address     (o_address),
        .o_rw          (o_rw),
        .o_data        (o_data)
`ifdef OAM_DMA_STALL_COUNT_EN
        ,
        .o_stall_cycles(o_stall_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Bus model: memory byte at an address is its low byte xor a pattern
    assign i_bus_data = o_address[7:0] ^ bus_mask;

    // Reference parity flop
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) tb_get <= 1'b0;
        else            tb_get <= ~tb_get;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] page;
        logic [7:0] mask;
        int         extra;      // core write cycles after the trigger
        int         halt_par;   // r_get value in the halt cycle
        int         inject_k;   // cycle to replay a trigger write (0 = none)
        int         exp_low;    // RDY-low cycles
        int         exp_first;  // first DMA-active cycle after trigger
    } vec_t;

    // Runs one transfer and checks ordering, data, stall length and exit
    task automatic run_xfer(input vec_t v, input bit abort, input string tag);
        int low, first_act, op_err, writes, k;
        logic [7:0] idx;
        bit exp_read, prev_final, done, p_trig;
        low = 0; first_act = 0; op_err = 0; writes = 0;
        idx = 8'h00; exp_read = 1'b1; prev_final = 1'b0; done = 1'b0;
        bus_mask = v.mask;
        p_trig = v.halt_par[0] ^ ((v.extra + 1) % 2 == 1);
        @(negedge i_clk);
        while (tb_get != p_trig) @(negedge i_clk);
        i_cpu_address = DMA_REG_ADDRESS_DEFAULT;
        i_cpu_rw = 1'b0;
        i_cpu_data = v.page;
        for (k = 1; k <= 700; k++) begin
            @(negedge i_clk);
            if (o_rdy) begin
                done = 1'b1;
                break;
            end
            low++;
            prev_final = 1'b0;
            if (o_dma_active) begin
                if (first_act == 0) first_act = k;
                if (o_rw) begin
                    if (!exp_read || o_address != {v.page, idx}) op_err++;
                    if (abort && idx == 8'h40) begin
                        i_reset_n = 1'b0;
                        i_cpu_address = 16'h0000;
                        i_cpu_rw = 1'b1;
                        @(negedge i_clk);
                        chk({tag, " rst rdy"}, o_rdy, 1);
                        chk({tag, " rst active"}, o_dma_active, 0);
                        chk({tag, " rst rw"}, o_rw, 1);
                        chk({tag, " rst addr"}, o_address, 16'h0000);
                        i_reset_n = 1'b1;
                        return;
                    end
                    exp_read = 1'b0;
                end else begin
                    if (exp_read || o_address != OAMDATA_ADDRESS_DEFAULT ||
                        o_data != (idx ^ v.mask)) op_err++;
                    if (idx == 8'hFF) prev_final = 1'b1;
                    idx = idx + 8'd1;
                    writes++;
                    exp_read = 1'b1;
                end
            end
            i_cpu_address = 16'h0300 + 16'(k);
            i_cpu_rw = (k <= v.extra) ? 1'b0 : 1'b1;
            i_cpu_data = 8'h00;
            if (k == v.inject_k) begin
                i_cpu_address = DMA_REG_ADDRESS_DEFAULT;
                i_cpu_rw = 1'b0;
                i_cpu_data = 8'h77;
            end
        end
        i_cpu_address = 16'h0000;
        i_cpu_rw = 1'b1;
        if (!done) begin
            chk({tag, " timeout"}, 0, 1);
            return;
        end
        chk({tag, " rdy_low"}, low, v.exp_low);
        chk({tag, " first_active"}, first_act, v.exp_first);
        chk({tag, " op_errors"}, op_err, 0);
        chk({tag, " writes"}, writes, 256);
        chk({tag, " end_active"}, o_dma_active, 0);
        chk({tag, " final_write_last"}, prev_final, 1);
`ifdef OAM_DMA_STALL_COUNT_EN
        chk({tag, " stall_cycles"}, o_stall_cycles, v.exp_low);
`endif
    endtask

    vec_t vecs[6];
    vec_t restart;

    initial begin
        vecs[0] = '{8'h02, 8'hA5, 0, 0,   0, 513, 2};
        vecs[1] = '{8'h02, 8'h00, 0, 1,   0, 514, 3};
        vecs[2] = '{8'h80, 8'h00, 2, 0,   0, 515, 4};
        vecs[3] = '{8'h80, 8'h3C, 2, 1,   0, 516, 5};
        vecs[4] = '{8'hFF, 8'h00, 0, 0, 100, 513, 2};
        vecs[5] = '{8'h00, 8'h00, 1, 1,   0, 515, 4};
        restart = '{8'h02, 8'h00, 0, 0,   0, 513, 2};

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("reset rdy", o_rdy, 1);
        chk("reset active", o_dma_active, 0);
        chk("reset rw", o_rw, 1);
        chk("reset addr", o_address, 16'h0000);
        chk("reset data", o_data, 8'h00);
`ifdef OAM_DMA_STALL_COUNT_EN
        chk("reset stall", o_stall_cycles, 0);
`endif
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i], 1'b0, $sformatf("vec%0d", i));
            repeat (3) @(negedge i_clk);
        end

        // Reset while reading index $40, then a fresh transfer from index 0
        run_xfer(restart, 1'b1, "abort");
        repeat (2) @(negedge i_clk);
        chk("idle after abort", o_rdy, 1);
        run_xfer(restart, 1'b0, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
